// File: rtl/cdb_writeback_queue_if.sv
// CDB result lanes plus the single write-back port of the writeback queue.
// master = FU/consumer side, slave = cdb_writeback_queue.
interface cdb_writeback_queue_if #(
  parameter int unsigned NUM_FU = 4,
  parameter int unsigned PREG_W = 7,
  parameter int unsigned VAL_W  = 32,
  parameter int unsigned TAG_W  = 5,
  parameter int unsigned PC_W   = 32
);
  // CDB side: one lane per functional unit
  logic [NUM_FU-1:0]        cdb_valid;
  logic [NUM_FU*PREG_W-1:0] cdb_register_addr;
  logic [NUM_FU*VAL_W-1:0]  cdb_register_val;
  logic [NUM_FU*TAG_W-1:0]  cdb_inst_tag;
  logic [NUM_FU*PC_W-1:0]   cdb_pc_out;
  logic [NUM_FU-1:0]        cdb_branch_taken_out;
  logic                     cdb_ready;

  // Write-back side: head of the queue
  logic                     wb_valid;
  logic                     wb_ready;
  logic [PREG_W-1:0]        wb_register_addr;
  logic [VAL_W-1:0]         wb_register_val;
  logic [TAG_W-1:0]         wb_inst_tag;
  logic [PC_W-1:0]          wb_pc;
  logic                     wb_branch_taken;

  modport master (
    output cdb_valid, cdb_register_addr, cdb_register_val, cdb_inst_tag, cdb_pc_out,
           cdb_branch_taken_out, wb_ready,
    input  cdb_ready, wb_valid, wb_register_addr, wb_register_val, wb_inst_tag, wb_pc,
           wb_branch_taken
  );

  modport slave (
    input  cdb_valid, cdb_register_addr, cdb_register_val, cdb_inst_tag, cdb_pc_out,
           cdb_branch_taken_out, wb_ready,
    output cdb_ready, wb_valid, wb_register_addr, wb_register_val, wb_inst_tag, wb_pc,
           wb_branch_taken
  );
endinterface

// File: rtl/cdb_writeback_queue.sv
// CDB receive queue: compacts up to NUM_FU result lanes per cycle into a circular FIFO and
// drains one entry per cycle. Optional sticky drop checker under CDB_WBQ_DROP_CHK_EN.
module cdb_writeback_queue #(
  parameter int unsigned NUM_FU = 4,
  parameter int unsigned PREG_W = 7,
  parameter int unsigned VAL_W  = 32,
  parameter int unsigned TAG_W  = 5,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  cdb_writeback_queue_if.slave     bus,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     err_drop
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  // Storage is deliberately not reset; pointers/occupancy define validity.
  logic [PREG_W-1:0] mem_addr [DEPTH];
  logic [VAL_W-1:0]  mem_val  [DEPTH];
  logic [TAG_W-1:0]  mem_tag  [DEPTH];
  logic [PC_W-1:0]   mem_pc   [DEPTH];
  logic              mem_bt   [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [OCC_W-1:0] free_cnt;
  logic [OCC_W-1:0] n_push;
  logic [PTR_W-1:0] slot [NUM_FU];
  logic             push_en;
  logic             pop_en;

  // Ready looks only at registered occupancy so it never loops back through producers.
  always_comb begin
    free_cnt      = OCC_W'(DEPTH) - occ_q;
    bus.cdb_ready = (free_cnt >= OCC_W'(NUM_FU));
  end

  // Compaction: each valid lane lands at tail plus the number of valid lanes below it.
  always_comb begin
    n_push = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      slot[i] = tail_q + n_push[PTR_W-1:0];
      n_push  = n_push + OCC_W'(bus.cdb_valid[i]);
    end
  end

  always_comb begin
    push_en = bus.cdb_ready;
    pop_en  = bus.wb_valid & bus.wb_ready;
    head_d  = head_q + PTR_W'(pop_en);
    tail_d  = tail_q;
    occ_d   = occ_q - OCC_W'(pop_en);
    if (push_en) begin
      tail_d = tail_q + n_push[PTR_W-1:0];
      occ_d  = occ_q + n_push - OCC_W'(pop_en);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (bus.cdb_valid[i]) begin
          mem_addr[slot[i]] <= bus.cdb_register_addr[i*PREG_W +: PREG_W];
          mem_val[slot[i]]  <= bus.cdb_register_val[i*VAL_W +: VAL_W];
          mem_tag[slot[i]]  <= bus.cdb_inst_tag[i*TAG_W +: TAG_W];
          mem_pc[slot[i]]   <= bus.cdb_pc_out[i*PC_W +: PC_W];
          mem_bt[slot[i]]   <= bus.cdb_branch_taken_out[i];
        end
      end
    end
  end

  // Head fields are forced to zero when empty so stale storage never shows after reset.
  always_comb begin
    bus.wb_valid         = (occ_q != '0);
    bus.wb_register_addr = '0;
    bus.wb_register_val  = '0;
    bus.wb_inst_tag      = '0;
    bus.wb_pc            = '0;
    bus.wb_branch_taken  = 1'b0;
    if (bus.wb_valid) begin
      bus.wb_register_addr = mem_addr[head_q];
      bus.wb_register_val  = mem_val[head_q];
      bus.wb_inst_tag      = mem_tag[head_q];
      bus.wb_pc            = mem_pc[head_q];
      bus.wb_branch_taken  = mem_bt[head_q];
    end
  end

  assign occupancy = occ_q;

`ifdef CDB_WBQ_DROP_CHK_EN
  localparam int unsigned LANES_W = NUM_FU * (PREG_W + VAL_W + TAG_W + PC_W + 2);

  logic [LANES_W-1:0] lanes_now, lanes_q;
  logic               stall_now, stall_q;
  logic               drop_event;
  logic               err_q;

  assign lanes_now = {bus.cdb_valid, bus.cdb_register_addr, bus.cdb_register_val,
                      bus.cdb_inst_tag, bus.cdb_pc_out, bus.cdb_branch_taken_out};

  // Only a stall following a stall is compared; the first refused cycle has no reference.
  always_comb begin
    stall_now  = !bus.cdb_ready && (|bus.cdb_valid);
    drop_event = stall_now && stall_q && (lanes_now != lanes_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q  <= 1'b0;
      lanes_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      stall_q  <= stall_now;
      lanes_q  <= lanes_now;
      if (drop_event) begin
        err_q <= 1'b1;
      end
      assert (!drop_event);
    end
  end

  assign err_drop = err_q;
`else
  assign err_drop = 1'b0;
`endif

endmodule

// File: tb/tb_cdb_writeback_queue.sv
// Scoreboard bench for cdb_writeback_queue: accepted lanes are queued in FU order and
// compared against every write-back transfer; occupancy/ready/valid are checked each cycle.
module tb_cdb_writeback_queue;
  localparam int unsigned NUM_FU = 4;
  localparam int unsigned PREG_W = 7;
  localparam int unsigned VAL_W  = 32;
  localparam int unsigned TAG_W  = 5;
  localparam int unsigned PC_W   = 32;
  localparam int unsigned DEPTH  = 8;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [PREG_W-1:0] addr;
    logic [VAL_W-1:0]  val;
    logic [PC_W-1:0]   pc;
    logic              bt;
  } entry_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] occupancy;
  logic       err_drop;

  entry_t sb[$];
  int     n_checks = 0;
  int     n_errors = 0;
  int     tag_ctr  = 0;

  cdb_writeback_queue_if #(
    .NUM_FU(NUM_FU), .PREG_W(PREG_W), .VAL_W(VAL_W), .TAG_W(TAG_W), .PC_W(PC_W)
  ) bus ();

  cdb_writeback_queue #(
    .NUM_FU(NUM_FU), .PREG_W(PREG_W), .VAL_W(VAL_W), .TAG_W(TAG_W), .PC_W(PC_W),
    .DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .occupancy(occupancy),
    .err_drop (err_drop)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string name, input logic [127:0] got,
                           input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Model: occupancy is the scoreboard depth; pop then push, push gated by pre-edge space.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
    end else begin
      int     depth_before;
      bit     model_ready;
      entry_t exp_e;
      entry_t got_e;
      depth_before = sb.size();
      model_ready  = (int'(DEPTH) - depth_before) >= int'(NUM_FU);
      check_val("occupancy", occupancy, depth_before);
      check_val("cdb_ready", bus.cdb_ready, model_ready);
      check_val("wb_valid", bus.wb_valid, depth_before != 0);
      if (bus.wb_valid && bus.wb_ready && depth_before != 0) begin
        exp_e = sb.pop_front();
        got_e = '{tag: bus.wb_inst_tag, addr: bus.wb_register_addr, val: bus.wb_register_val,
                  pc: bus.wb_pc, bt: bus.wb_branch_taken};
        check_val("wb_entry", got_e, exp_e);
      end
      if (model_ready) begin
        for (int i = 0; i < int'(NUM_FU); i++) begin
          if (bus.cdb_valid[i]) begin
            sb.push_back('{tag:  bus.cdb_inst_tag[i*TAG_W +: TAG_W],
                           addr: bus.cdb_register_addr[i*PREG_W +: PREG_W],
                           val:  bus.cdb_register_val[i*VAL_W +: VAL_W],
                           pc:   bus.cdb_pc_out[i*PC_W +: PC_W],
                           bt:   bus.cdb_branch_taken_out[i]});
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic [TAG_W-1:0] t, input logic [PREG_W-1:0] a,
                          input logic [VAL_W-1:0] v);
    bus.cdb_inst_tag[i*TAG_W +: TAG_W]       = t;
    bus.cdb_register_addr[i*PREG_W +: PREG_W] = a;
    bus.cdb_register_val[i*VAL_W +: VAL_W]    = v;
    bus.cdb_pc_out[i*PC_W +: PC_W]            = $urandom;
    bus.cdb_branch_taken_out[i]               = t[0];
  endtask

  task automatic load_burst(input logic [3:0] v);
    for (int i = 0; i < int'(NUM_FU); i++) begin
      if (v[i]) begin
        set_lane(i, TAG_W'(tag_ctr), PREG_W'(tag_ctr * 3 + i), $urandom);
        tag_ctr++;
      end
    end
    bus.cdb_valid = v;
  endtask

  // Producer protocol: hold lanes until an edge with cdb_ready high.
  task automatic send(input logic [3:0] v);
    bit ok;
    int k;
    load_burst(v);
    k = 0;
    do begin
      ok = bus.cdb_ready;
      tick();
      k++;
    end while (!ok && k < 64);
    if (!ok) check_val("send_timeout", 0, 1);
    bus.cdb_valid = '0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 100) begin
      tick();
      k++;
    end
    tick();
    check_val("drain_done", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset                    = 1'b1;
    bus.cdb_valid            = '0;
    bus.cdb_register_addr    = '0;
    bus.cdb_register_val     = '0;
    bus.cdb_inst_tag         = '0;
    bus.cdb_pc_out           = '0;
    bus.cdb_branch_taken_out = '0;
    bus.wb_ready             = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset / idle
    check_val("rst_cdb_ready", bus.cdb_ready, 1);
    check_val("rst_wb_valid", bus.wb_valid, 0);
    check_val("rst_occupancy", occupancy, 0);
    check_val("rst_err_drop", err_drop, 0);
    check_val("rst_wb_val", bus.wb_register_val, 0);
    check_val("rst_wb_tag", bus.wb_inst_tag, 0);

    // Single push on lane 2
    bus.wb_ready = 1'b1;
    set_lane(2, 5'd3, 7'd12, 32'hDEAD_BEEF);
    bus.cdb_valid = 4'b0100;
    tick();
    bus.cdb_valid = '0;
    check_val("single_valid", bus.wb_valid, 1);
    check_val("single_addr", bus.wb_register_addr, 7'd12);
    check_val("single_val", bus.wb_register_val, 32'hDEAD_BEEF);
    check_val("single_tag", bus.wb_inst_tag, 5'd3);
    tick();
    check_val("single_empty", bus.wb_valid, 0);

    // Compaction: lanes 0,1,3 emerge as tags 1,2,4
    set_lane(0, 5'd1, 7'd20, $urandom);
    set_lane(1, 5'd2, 7'd21, $urandom);
    set_lane(3, 5'd4, 7'd23, $urandom);
    bus.cdb_valid = 4'b1011;
    tick();
    bus.cdb_valid = '0;
    check_val("cmp_tag0", bus.wb_inst_tag, 5'd1);
    tick();
    check_val("cmp_tag1", bus.wb_inst_tag, 5'd2);
    tick();
    check_val("cmp_tag2", bus.wb_inst_tag, 5'd4);
    tick();
    check_val("cmp_empty", bus.wb_valid, 0);

    // Backpressure: fill, hold a third burst, then release
    bus.wb_ready = 1'b0;
    send(4'b1111);
    send(4'b1111);
    check_val("bp_full_occ", occupancy, 8);
    check_val("bp_full_ready", bus.cdb_ready, 0);
    load_burst(4'b1111);
    tick();
    tick();
    check_val("bp_held_occ", occupancy, 8);
    bus.wb_ready = 1'b1;
    repeat (3) tick();
    check_val("bp_occ5_ready", bus.cdb_ready, 0);
    tick();
    check_val("bp_occ4_ready", bus.cdb_ready, 1);
    check_val("bp_occ4", occupancy, 4);
    tick();
    bus.cdb_valid = '0;
    check_val("bp_accept_occ", occupancy, 7);
    drain();

    // Steady single-lane stream across pointer wrap
    for (int c = 0; c < 20; c++) begin
      load_burst(4'b0001);
      tick();
      check_val("stream_occ", occupancy, 1);
    end
    bus.cdb_valid = '0;
    drain();

    // Asynchronous reset with 5 entries queued
    bus.wb_ready = 1'b0;
    send(4'b1111);
    send(4'b0001);
    check_val("mid_occ5", occupancy, 5);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check_val("mid_rst_valid", bus.wb_valid, 0);
    check_val("mid_rst_occ", occupancy, 0);
    check_val("mid_rst_ready", bus.cdb_ready, 1);
    tick();
    reset = 1'b0;
    bus.wb_ready = 1'b1;
    repeat (4) begin
      tick();
      check_val("post_rst_valid", bus.wb_valid, 0);
    end

    check_val("final_err_drop", err_drop, 0);
    check_val("final_sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
